fir_ctrl: RTL and testbench
===========================

# fir_ctrl

Control FSM for the folded 8-tap FIR datapath `dp`. It sequences the datapath control pins (`x_clr`, `shift`, `ctrl_1`, `y_clr`, `y_en`, `valid`) once per input sample and wraps the filter in a valid/ready input handshake and a valid/ready output handshake. It sits between the sample source and `dp`, and drives the datapath's only control interface. The datapath itself has no reset; this block clears it.

## Interface
- `CNT_W`, default 16: width of the delivered-output counter.

- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: source presents a sample on the `dp` `x` input.
- `in_ready` out 1: a sample is accepted on the rising edge where `in_valid & in_ready`.
- `out_ready` in 1: the sink accepts `y` on the rising edge where `out_valid & out_ready`.
- `out_valid` out 1: `dp` `y` holds a finished output.
- `flush` in 1: synchronous clear of the delay line and the block state.
- `x_clr` out 1: to `dp` `x_clr`.
- `shift` out 1: to `dp` `shift`.
- `ctrl_1` out 2: to `dp` `ctrl_1`, the tap-pair select.
- `y_clr` out 1: to `dp` `y_clr`.
- `y_en` out 1: to `dp` `y_en`.
- `valid` out 1: to `dp` `valid`. Always equal to `out_valid`.
- `y_warm` out 1: qualifies `out_valid`. The output has 8 real samples in its window.
- `n_out` out `CNT_W`: count of delivered outputs, wrapping.

## Operation
- States: INIT, IDLE, MAC0, MAC1, MAC2, OUT.
- INIT
  - `x_clr`=1; all other controls 0; `in_ready`=0.
  - Goes to IDLE unconditionally after one cycle.
- IDLE
  - `in_ready`=1.
  - `shift` = `in_valid`.
  - On accept, goes to MAC0.
- MAC0: `ctrl_1`=0, `y_clr`=1. Loads z with pair (x0·b0 + x1·b1). Goes to MAC1.
- MAC1: `ctrl_1`=1, `y_en`=1. Goes to MAC2.
- MAC2: `ctrl_1`=2, `y_en`=1. Goes to OUT.
- OUT
  - `ctrl_1`=3, `valid`=`out_valid`=1. `dp` `y` is combinational z + pair 3.
  - Holds every control unchanged while `out_ready`=0.
  - `in_ready` = `out_ready` (combinational path; documented).
  - `out_ready` & `in_valid`: `shift`=1, go to MAC0 (back-to-back).
  - `out_ready` & !`in_valid`: go to IDLE.
- The shift in OUT is legal: `y` is sampled by the sink on the same edge that updates `x_shift`.
- `ctrl_1` is 0 in INIT and IDLE.
- `y_en` and `y_clr` are never high together. `shift` is high only on an accept edge.
- Warm counter (0..8, saturating at 8):
  - Increments on each accept.
  - `y_warm` = `out_valid` & (count == 8).
  - Cleared by reset and by `flush`.
- `n_out`: increments by 1 on each output handshake and wraps at 2^`CNT_W`. Reset to 0. Not cleared by `flush`.
- `flush` has priority over everything:
  - `x_clr`=1, `in_ready`=0, `shift`=0, `out_valid`=0.
  - Next state is IDLE. Any in-flight or held output is discarded and not counted.

## Timing
- Reset values while `rst_n`=0:
  - State INIT, so `x_clr`=1.
  - `shift`, `y_clr`, `y_en`, `valid`, `out_valid`, `in_ready`, `y_warm` = 0; `ctrl_1`=0; `n_out`=0.
- After reset release: one INIT cycle, then IDLE with `in_ready`=1.
- Latency: a sample accepted on edge t gives `out_valid`=1 in the cycle after edge t+3 (MAC0, MAC1, MAC2, then OUT).
- Throughput: one sample per 4 cycles with `in_valid` and `out_ready` held high. 5 cycles when each input arrives only after a return to IDLE.
- Backpressure: in OUT, z and `x_shift` are frozen, so `y` is stable for any number of stall cycles.
- `flush` together with `in_valid`: the sample is not accepted.
- `flush` in OUT together with `out_ready`: no handshake, and `n_out` is unchanged.
- `rst_n` asserted mid-sequence: immediate return to INIT, with `n_out` and the warm counter cleared.

## Test plan
- **Reset/clear.** Release reset.
  - `x_clr` is high for exactly 1 cycle, then `in_ready`=1.
  - Impulse x=127 then zeros, `out_ready`=1: y sequence is 1,7,20,30,30,20,7,1, then 0. Values are floor((127·b)/128) for b = 2,8,21,31,31,21,8,2.
- **Constant streaming.** x=64 held, `in_valid`=`out_ready`=1.
  - One output per 4 cycles.
  - `y_warm` is first high on the 8th output, with y=62.
  - `n_out` increments by 1 per output.
- **Backpressure.** Hold `out_ready`=0 for 10 cycles in OUT.
  - `y`, `ctrl_1`=3 and `in_ready`=0 stay stable.
  - Release: exactly one handshake, `n_out`+1.
- **Flush.** Assert `flush` in MAC1 and again in OUT with `out_ready`=1.
  - Both: state goes to IDLE, `x_clr`=1, no output, `n_out` unchanged.
  - Next sample: `y_warm`=0 until 8 new samples are accepted.
- **Gapped input.** `in_valid` pulses every 7 cycles.
  - OUT goes to IDLE each time; 5-cycle latency-to-idle pattern.
  - `shift` is high only on accept edges.
- **Async reset mid-OUT.** Pull `rst_n` low while `out_valid`=1.
  - `out_valid` drops immediately; `n_out`=0; INIT follows on release.

Source files
------------

// File: rtl/fir_ctrl.sv
// rtl/fir_ctrl.sv - control FSM sequencing the folded 8-tap FIR datapath
// with valid/ready handshakes on input samples and finished outputs.
module fir_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             out_valid,
  input  logic             flush,
  output logic             x_clr,
  output logic             shift,
  output logic [1:0]       ctrl_1,
  output logic             y_clr,
  output logic             y_en,
  output logic             valid,
  output logic             y_warm,
  output logic [CNT_W-1:0] n_out
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_MAC0,
    S_MAC1,
    S_MAC2,
    S_OUT
  } state_t;

  state_t     state;
  state_t     nxt;
  logic       init_q;
  logic       idle_q;
  logic       out_q;
  logic [1:0] ctrl_q;
  logic       y_clr_q;
  logic       y_en_q;
  logic [3:0] warm;
  logic       accept;
  logic       out_hs;

  // flush overrides the state-decoded handshake and clear pins in the same cycle
  assign in_ready  = ~flush & (idle_q | (out_q & out_ready));
  assign accept    = in_valid & in_ready;
  assign shift     = accept;
  assign out_valid = out_q & ~flush;
  assign valid     = out_valid;
  assign out_hs    = out_valid & out_ready;
  assign x_clr     = init_q | flush;
  assign ctrl_1    = ctrl_q;
  assign y_clr     = y_clr_q;
  assign y_en      = y_en_q;
  assign y_warm    = out_valid & (warm == 4'd8);

  always_comb begin
    nxt = state;
    case (state)
      S_INIT: nxt = S_IDLE;
      S_IDLE: if (accept) nxt = S_MAC0;
      S_MAC0: nxt = S_MAC1;
      S_MAC1: nxt = S_MAC2;
      S_MAC2: nxt = S_OUT;
      S_OUT:  if (out_hs) nxt = accept ? S_MAC0 : S_IDLE;
      default: nxt = S_INIT;
    endcase
    if (flush) nxt = S_IDLE;
  end

  // Control pins are registered from the next state so they change with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_INIT;
      init_q  <= 1'b1;
      idle_q  <= 1'b0;
      out_q   <= 1'b0;
      ctrl_q  <= 2'd0;
      y_clr_q <= 1'b0;
      y_en_q  <= 1'b0;
      warm    <= 4'd0;
      n_out   <= '0;
    end else begin
      state   <= nxt;
      init_q  <= (nxt == S_INIT);
      idle_q  <= (nxt == S_IDLE);
      out_q   <= (nxt == S_OUT);
      y_clr_q <= (nxt == S_MAC0);
      y_en_q  <= (nxt == S_MAC1) || (nxt == S_MAC2);
      case (nxt)
        S_MAC1:  ctrl_q <= 2'd1;
        S_MAC2:  ctrl_q <= 2'd2;
        S_OUT:   ctrl_q <= 2'd3;
        default: ctrl_q <= 2'd0;
      endcase
      if (flush) warm <= 4'd0;
      else if (accept && (warm != 4'd8)) warm <= warm + 4'd1;
      if (out_hs) n_out <= n_out + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_fir_ctrl.sv
// tb/tb_fir_ctrl.sv - bench for fir_ctrl driving a behavioural FIR datapath
// and comparing its outputs with a direct convolution of accepted samples.
module tb_fir_ctrl;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic flush = 1'b0;
  logic [7:0] x = 8'd0;
  logic in_ready, out_valid, x_clr, shift, y_clr, y_en, valid, y_warm;
  logic [1:0] ctrl_1;
  logic [CNT_W-1:0] n_out;

  fir_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .out_ready(out_ready), .out_valid(out_valid), .flush(flush),
    .x_clr(x_clr), .shift(shift), .ctrl_1(ctrl_1), .y_clr(y_clr),
    .y_en(y_en), .valid(valid), .y_warm(y_warm), .n_out(n_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  int b[8] = '{2, 8, 21, 31, 31, 21, 8, 2};

  // datapath model state and reference bookkeeping
  int x_sh[8];
  int z = 0;
  int y_mon = 0;
  int pz, s_ref;
  longint cyc = 0;
  int acc_cnt = 0;
  int acc_total = 0;
  logic [CNT_W-1:0] exp_n = '0;

  typedef struct { int y; int w; longint cyc; int n; } rec_t;
  typedef struct { int y; int w; } exp_t;
  rec_t recs[$];
  exp_t pend[$];
  int   hist[$];

  function automatic int pair(input int p);
    return x_sh[2*p] * b[2*p] + x_sh[2*p+1] * b[2*p+1];
  endfunction

  initial begin
    foreach (x_sh[k]) x_sh[k] = 0;
    forever begin
      @(negedge clk);
      cyc++;
      y_mon = (z + pair(3)) / 128;
      if (!rst_n) begin
        chk("rst_x_clr", x_clr, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_n_out", n_out, 0);
        chk("rst_y_warm", y_warm, 0);
        chk("rst_ctl", {shift, y_clr, y_en, valid, ctrl_1}, 0);
        pend.delete(); hist.delete(); acc_cnt = 0; exp_n = '0;
      end else begin
        chk("valid_eq", valid, out_valid);
        chk("yen_yclr_excl", y_en & y_clr, 0);
        chk("shift_accept", shift, in_valid & in_ready);
        chk("n_out", n_out, exp_n);
        if (in_ready && !out_valid) chk("idle_ctrl", ctrl_1, 0);
        if (out_valid) begin
          chk("out_ctrl", ctrl_1, 3);
          if (pend.size() == 0) chk("spurious_out", 1, 0);
          else begin
            chk("y", y_mon, pend[0].y);
            chk("y_warm", y_warm, pend[0].w);
          end
        end else chk("y_warm_idle", y_warm, 0);
        if (out_valid && out_ready) begin
          recs.push_back('{y_mon, int'(y_warm), cyc, int'(n_out)});
          if (pend.size() > 0) void'(pend.pop_front());
          exp_n++;
        end
        if (flush) begin
          pend.delete(); hist.delete(); acc_cnt = 0;
        end
        if (in_valid && in_ready) begin
          hist.push_front(int'(x));
          if (hist.size() > 8) void'(hist.pop_back());
          acc_cnt = (acc_cnt < 8) ? acc_cnt + 1 : 8;
          acc_total++;
          s_ref = 0;
          foreach (hist[k]) s_ref += hist[k] * b[k];
          pend.push_back('{s_ref / 128, int'(acc_cnt == 8)});
        end
      end
      pz = pair(int'(ctrl_1));
      if (y_clr) z = pz;
      else if (y_en) z = z + pz;
      if (x_clr) foreach (x_sh[k]) x_sh[k] = 0;
      else if (shift) begin
        for (int k = 7; k > 0; k--) x_sh[k] = x_sh[k-1];
        x_sh[0] = int'(x);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    repeat (8) tick();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic send(input int xv);
    int ok = 0;
    x = 8'(xv);
    in_valid = 1'b1;
    for (int i = 0; i < 40 && ok == 0; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      tick();
    end
    chk("send_accept", ok, 1);
  endtask

  task automatic wait_recs(input int n);
    for (int i = 0; i < 200 && recs.size() < n; i++) tick();
    chk("recs_count", recs.size(), n);
  endtask

  task automatic wait_out_valid(input string name);
    int ok = 0;
    for (int i = 0; i < 12 && ok == 0; i++) begin
      if (out_valid) ok = 1;
      else tick();
    end
    chk(name, ok, 1);
  endtask

  typedef struct { int iv, orr, fl, rdy, xclr, sh, ctrl, yclr, yen, ov; } vec_t;
  vec_t tbl[18];
  int imp[9] = '{1, 7, 20, 30, 30, 20, 7, 1, 0};

  initial begin
    int y0, a0;
    logic [CNT_W-1:0] n0;
    tbl[0]  = '{0,1,0, 0,1,0,0,0,0,0};
    tbl[1]  = '{0,1,0, 1,0,0,0,0,0,0};
    tbl[2]  = '{1,1,0, 1,0,1,0,0,0,0};
    tbl[3]  = '{0,1,0, 0,0,0,0,1,0,0};
    tbl[4]  = '{0,1,0, 0,0,0,1,0,1,0};
    tbl[5]  = '{0,1,0, 0,0,0,2,0,1,0};
    tbl[6]  = '{1,0,0, 0,0,0,3,0,0,1};
    tbl[7]  = '{1,1,0, 1,0,1,3,0,0,1};
    tbl[8]  = '{0,1,0, 0,0,0,0,1,0,0};
    tbl[9]  = '{0,1,1, 0,1,0,1,0,1,0};
    tbl[10] = '{1,1,0, 1,0,1,0,0,0,0};
    tbl[11] = '{0,1,0, 0,0,0,0,1,0,0};
    tbl[12] = '{0,1,0, 0,0,0,1,0,1,0};
    tbl[13] = '{0,1,0, 0,0,0,2,0,1,0};
    tbl[14] = '{0,1,1, 0,1,0,3,0,0,0};
    tbl[15] = '{0,1,0, 1,0,0,0,0,0,0};
    tbl[16] = '{1,1,1, 0,1,0,0,0,0,0};
    tbl[17] = '{0,1,0, 1,0,0,0,0,0,0};

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      in_valid  = (tbl[i].iv != 0);
      out_ready = (tbl[i].orr != 0);
      flush     = (tbl[i].fl != 0);
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", i), in_ready, tbl[i].rdy);
      chk($sformatf("v%0d_x_clr", i), x_clr, tbl[i].xclr);
      chk($sformatf("v%0d_shift", i), shift, tbl[i].sh);
      chk($sformatf("v%0d_ctrl_1", i), ctrl_1, tbl[i].ctrl);
      chk($sformatf("v%0d_y_clr", i), y_clr, tbl[i].yclr);
      chk($sformatf("v%0d_y_en", i), y_en, tbl[i].yen);
      chk($sformatf("v%0d_out_valid", i), out_valid, tbl[i].ov);
      tick();
    end
    chk("table_n_out", n_out, 1);

    // impulse response
    go_idle(); do_flush(); recs.delete();
    for (int i = 0; i < 9; i++) send(i == 0 ? 127 : 0);
    in_valid = 1'b0;
    wait_recs(9);
    for (int i = 0; i < 9 && i < recs.size(); i++)
      chk($sformatf("impulse_y%0d", i), recs[i].y, imp[i]);

    // constant streaming
    go_idle(); do_flush(); recs.delete();
    for (int i = 0; i < 10; i++) send(64);
    in_valid = 1'b0;
    wait_recs(10);
    if (recs.size() == 10) begin
      for (int i = 1; i < 10; i++)
        chk($sformatf("const_gap%0d", i), recs[i].cyc - recs[i-1].cyc, 4);
      chk("const_warm7", recs[6].w, 0);
      chk("const_warm8", recs[7].w, 1);
      chk("const_y8", recs[7].y, 62);
      chk("const_n_step", (recs[9].n - recs[0].n) & ((1 << CNT_W) - 1), 9);
    end

    // backpressure
    go_idle(); recs.delete();
    out_ready = 1'b0;
    send(50);
    x = 8'd77;
    wait_out_valid("bp_reach_out");
    @(negedge clk); #1;
    y0 = y_mon;
    repeat (10) begin
      @(negedge clk); #1;
      chk("bp_y", y_mon, y0);
      chk("bp_ctrl_1", ctrl_1, 3);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    n0 = n_out;
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b0;
    repeat (6) tick();
    chk("bp_n_out", n_out, CNT_W'(n0 + 1'b1));
    chk("bp_one_hs", recs.size(), 1);

    // gapped input
    go_idle(); recs.delete();
    a0 = acc_total;
    for (int p = 0; p < 4; p++) begin
      in_valid = 1'b1; x = 8'(10 * p + 5);
      tick();
      in_valid = 1'b0;
      repeat (6) tick();
    end
    chk("gap_accepts", acc_total - a0, 4);
    chk("gap_outputs", recs.size(), 4);
    for (int i = 1; i < 4 && i < recs.size(); i++)
      chk($sformatf("gap_period%0d", i), recs[i].cyc - recs[i-1].cyc, 7);

    // asynchronous reset while holding an output
    go_idle();
    out_ready = 1'b0;
    send(90);
    in_valid = 1'b0;
    wait_out_valid("ar_reach_out");
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_n_out", n_out, 0);
    chk("ar_x_clr", x_clr, 1);
    chk("ar_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("ar_init_x_clr", x_clr, 1);
    chk("ar_init_in_ready", in_ready, 0);
    tick();
    @(negedge clk);
    chk("ar_idle_x_clr", x_clr, 0);
    chk("ar_idle_in_ready", in_ready, 1);
    tick();

    // randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      x         = 8'($urandom_range(0, 127));
      if (c == 1500) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    flush = 1'b0; in_valid = 1'b0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
